// File: rtl/fracbrg_mc.sv
// Multi-channel runtime-programmable fractional baud-rate generator.
// Each channel: phase accumulator -> oversample tick, bit tick every OVERSAMPLE os ticks.
module fracbrg_mc #(
   parameter int unsigned CLK_HZ     = 79027200,
   parameter int unsigned BAUDRATE   = 1000000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned RESOLUTION = 32,
   parameter int unsigned NUM_CH     = 4,
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CH_OS     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [NUM_CH-1:0]         en_i,
   input  logic [NUM_CH-1:0]         clr_i,
   input  logic                      wr_i,
   input  logic [CH_W-1:0]           wr_ch_i,
   input  logic [RESOLUTION-1:0]     wr_data_i,
   output logic [NUM_CH-1:0]         os_tick_o,
   output logic [NUM_CH-1:0]         bit_tick_o,
   output logic [NUM_CH*CH_OS-1:0]   phase_o,
   output logic [NUM_CH-1:0]         upd_pend_o
);

   // Round-to-nearest default increment, evaluated in 64-bit arithmetic.
   localparam logic [63:0] INC_NUM   = (64'(BAUDRATE) * 64'(OVERSAMPLE)) << RESOLUTION;
   localparam logic [63:0] INC_DEF64 = (INC_NUM + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
   localparam logic [RESOLUTION-1:0] INC_DEF = INC_DEF64[RESOLUTION-1:0];
   localparam logic [CH_OS-1:0] OS_LAST = CH_OS'(OVERSAMPLE - 1);

   if (INC_DEF64 == 64'd0 || INC_DEF64 >= (64'd1 << RESOLUTION)) begin : g_bad_inc
      $error("fracbrg_mc: default increment out of range");
   end

   logic [RESOLUTION-1:0] acc    [NUM_CH];
   logic [RESOLUTION-1:0] inc    [NUM_CH];
   logic [RESOLUTION-1:0] pend   [NUM_CH];
   logic [CH_OS-1:0]      os_cnt [NUM_CH];
   logic [RESOLUTION:0]   sum    [NUM_CH];
   logic [NUM_CH-1:0]     bit_edge;
   logic [NUM_CH-1:0]     apply;
   logic [NUM_CH-1:0]     wr_hit;

   always_comb begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         sum[ch]      = {1'b0, acc[ch]} + {1'b0, inc[ch]};
         bit_edge[ch] = en_i[ch] & ~clr_i[ch] & sum[ch][RESOLUTION] & (os_cnt[ch] == OS_LAST);
         // Rate changes only at bit boundaries, on clear, or while stopped.
         apply[ch]    = clr_i[ch] | ~en_i[ch] | bit_edge[ch];
         wr_hit[ch]   = wr_i & (wr_ch_i == CH_W'(ch));
      end
   end

   always_comb begin
      phase_o = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
         phase_o[ch*CH_OS +: CH_OS] = os_cnt[ch];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            acc[ch]    <= '0;
            os_cnt[ch] <= '0;
            inc[ch]    <= INC_DEF;
            pend[ch]   <= INC_DEF;
         end
         os_tick_o  <= '0;
         bit_tick_o <= '0;
         upd_pend_o <= '0;
      end else begin
         for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (clr_i[ch]) begin
               acc[ch]        <= '0;
               os_cnt[ch]     <= '0;
               os_tick_o[ch]  <= 1'b0;
               bit_tick_o[ch] <= 1'b0;
            end else if (en_i[ch]) begin
               acc[ch]        <= sum[ch][RESOLUTION-1:0];
               os_tick_o[ch]  <= sum[ch][RESOLUTION];
               bit_tick_o[ch] <= bit_edge[ch];
               if (sum[ch][RESOLUTION]) begin
                  os_cnt[ch] <= (os_cnt[ch] == OS_LAST) ? '0 : os_cnt[ch] + CH_OS'(1);
               end
            end else begin
               os_tick_o[ch]  <= 1'b0;
               bit_tick_o[ch] <= 1'b0;
            end

            // pend tracks a bypassed write too, so a later apply keeps the new rate.
            if (apply[ch]) begin
               inc[ch]        <= wr_hit[ch] ? wr_data_i : pend[ch];
               if (wr_hit[ch]) pend[ch] <= wr_data_i;
               upd_pend_o[ch] <= 1'b0;
            end else if (wr_hit[ch]) begin
               pend[ch]       <= wr_data_i;
               upd_pend_o[ch] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fracbrg_mc.sv
// Self-checking bench for fracbrg_mc: behavioural rate model plus directed literal checks.
module tb_fracbrg_mc;

   localparam int CLK_B  = 1024000;
   localparam int BAUD_B = 10000;
   localparam int OS     = 4;
   localparam int MOD    = 256;
   localparam int INC_B  = (BAUD_B * OS * MOD + CLK_B / 2) / CLK_B;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] en = '0;
   logic [1:0] clr = '0;
   logic       wr = 1'b0;
   logic       wr_ch = 1'b0;
   logic [7:0] wr_data = '0;
   logic [1:0] os_tick, bit_tick, upd_pend;
   logic [3:0] phase;

   logic        rst_def_n = 1'b0;
   logic        def_en = 1'b0;
   logic        def_os, def_bit, def_ph, def_up;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fracbrg_mc #(
      .CLK_HZ(CLK_B), .BAUDRATE(BAUD_B), .OVERSAMPLE(OS), .RESOLUTION(8), .NUM_CH(2)
   ) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .wr_i(wr), .wr_ch_i(wr_ch),
      .wr_data_i(wr_data), .os_tick_o(os_tick), .bit_tick_o(bit_tick), .phase_o(phase),
      .upd_pend_o(upd_pend)
   );

   fracbrg_mc #(
      .CLK_HZ(79027200), .BAUDRATE(1000000), .OVERSAMPLE(1), .RESOLUTION(32), .NUM_CH(1)
   ) u_def (
      .clk_i(clk), .rst_n_i(rst_def_n), .en_i(def_en), .clr_i(1'b0), .wr_i(1'b0),
      .wr_ch_i(1'b0), .wr_data_i(32'd0), .os_tick_o(def_os), .bit_tick_o(def_bit),
      .phase_o(def_ph), .upd_pend_o(def_up)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference: per channel, an integer phase modulo 2^8 advanced by the active rate.
   int m_acc[2], m_os[2], m_inc[2], m_pend[2];
   int e_os[2], e_bit[2], e_up[2];
   int m_sum, m_app, m_hit;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_os[c] = 0; m_inc[c] = INC_B; m_pend[c] = INC_B;
            e_os[c] = 0; e_bit[c] = 0; e_up[c] = 0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            m_hit = (wr && int'(wr_ch) == c) ? 1 : 0;
            if (clr[c]) begin
               m_acc[c] = 0; m_os[c] = 0; e_os[c] = 0; e_bit[c] = 0; m_app = 1;
            end else if (!en[c]) begin
               e_os[c] = 0; e_bit[c] = 0; m_app = 1;
            end else begin
               m_sum    = m_acc[c] + m_inc[c];
               e_os[c]  = (m_sum >= MOD) ? 1 : 0;
               e_bit[c] = (e_os[c] == 1 && m_os[c] == OS - 1) ? 1 : 0;
               m_acc[c] = m_sum % MOD;
               if (e_os[c] == 1) m_os[c] = (m_os[c] + 1) % OS;
               m_app = e_bit[c];
            end
            if (m_app == 1) begin
               if (m_hit == 1) m_pend[c] = int'(wr_data);
               m_inc[c] = m_pend[c];
               e_up[c] = 0;
            end else if (m_hit == 1) begin
               m_pend[c] = int'(wr_data);
               e_up[c] = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         chk("os_tick", int'(os_tick[c]), e_os[c]);
         chk("bit_tick", int'(bit_tick[c]), e_bit[c]);
         chk("phase", int'(phase[c*2 +: 2]), m_os[c]);
         chk("upd_pend", int'(upd_pend[c]), e_up[c]);
      end
   end

   task automatic start0(input logic [7:0] incv);
      wr = 1'b1; wr_ch = 1'b0; wr_data = incv; clr[0] = 1'b1; en[0] = 1'b0;
      @(negedge clk);
      wr = 1'b0; clr[0] = 1'b0; en[0] = 1'b1;
   endtask

   task automatic main_seq();
      int cnt;
      repeat (3) @(negedge clk);
      chk("rst_os", int'(os_tick), 0);
      chk("rst_bit", int'(bit_tick), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_upd", int'(upd_pend), 0);
      rst_n = 1'b1;
      en = 2'b11;
      repeat (40) @(negedge clk);
      en = 2'b00;
      @(negedge clk);

      // Rate 64/256: os tick every 4 clk, bit every 16.
      start0(8'd64);
      chk("t1_upd0", int'(upd_pend[0]), 0);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         chk("t1_os", int'(os_tick[0]), (k % 4 == 0) ? 1 : 0);
         chk("t1_bit", int'(bit_tick[0]), (k % 16 == 0) ? 1 : 0);
         if (k % 4 == 0) chk("t1_phase", int'(phase[1:0]), (k / 4) % 4);
      end

      // Rate 96/256: ticks at 3,6,8 then repeating; 300 in 800 clk.
      start0(8'd96);
      cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk);
         cnt += int'(os_tick[0]);
         if (k <= 8) chk("t2_os", int'(os_tick[0]), (k == 3 || k == 6 || k == 8) ? 1 : 0);
      end
      chk("t2_count800", cnt, 300);

      // Mid-bit write of 128 waits for the bit boundary at clk 16.
      start0(8'd64);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk("t3_os", int'(os_tick[0]), (k <= 16) ? ((k % 4 == 0) ? 1 : 0) : ((k % 2 == 0) ? 1 : 0));
         chk("t3_upd", int'(upd_pend[0]), (k >= 7 && k < 16) ? 1 : 0);
         if (k == 6) begin wr = 1'b1; wr_ch = 1'b0; wr_data = 8'd128; end
         if (k == 7) wr = 1'b0;
      end

      // Write landing on the bit-tick edge takes effect on the very next add.
      start0(8'd64);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         chk("t4_os", int'(os_tick[0]), (k <= 16) ? ((k % 4 == 0) ? 1 : 0) : ((k == 24) ? 1 : 0));
         chk("t4_upd", int'(upd_pend[0]), 0);
         if (k == 16) chk("t4_bit16", int'(bit_tick[0]), 1);
         if (k == 15) begin wr = 1'b1; wr_ch = 1'b0; wr_data = 8'd32; end
         if (k == 16) wr = 1'b0;
      end
      en[0] = 1'b0; wr = 1'b1; wr_ch = 1'b0; wr_data = 8'd200;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      chk("t4_upd_en0", int'(upd_pend[0]), 0);
      en[0] = 1'b1;
      repeat (20) @(negedge clk);

      // Randomised traffic checked by the reference model.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            en[c]  = ($urandom_range(0, 9) != 0);
            clr[c] = ($urandom_range(0, 59) == 0);
         end
         wr    = ($urandom_range(0, 5) == 0);
         wr_ch = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       wr_data = 8'd0;
            1:       wr_data = 8'd255;
            2, 3:    wr_data = 8'($urandom_range(1, 16));
            default: wr_data = 8'($urandom_range(1, 255));
         endcase
      end
      wr = 1'b0; clr = 2'b00;

      // Async reset mid-bit, then a clear on ch1 only.
      @(negedge clk);
      wr = 1'b1; wr_ch = 1'b1; wr_data = 8'd77; en = 2'b11; clr = 2'b10;
      @(negedge clk);
      wr = 1'b1; wr_ch = 1'b0; wr_data = 8'd50; clr = 2'b01;
      @(negedge clk);
      wr = 1'b0; clr = 2'b00;
      repeat (13) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_os", int'(os_tick), 0);
      chk("t6_rst_bit", int'(bit_tick), 0);
      chk("t6_rst_phase", int'(phase), 0);
      chk("t6_rst_upd", int'(upd_pend), 0);
      @(negedge clk);
      rst_n = 1'b1; en = 2'b11;
      repeat (37) @(negedge clk);
      clr = 2'b10;
      @(negedge clk);
      clr = 2'b00;
      chk("t6_ch1_phase", int'(phase[3:2]), 0);
      repeat (40) @(negedge clk);
   endtask

   task automatic def_seq();
      int cnt, bits, diff;
      cnt = 0; bits = 0; diff = 0;
      repeat (3) @(negedge clk);
      rst_def_n = 1'b1;
      @(negedge clk);
      def_en = 1'b1;
      while (bits < 1000 && cnt < 90000) begin
         @(negedge clk);
         cnt++;
         if (def_bit) bits++;
         if (def_bit != def_os) diff++;
      end
      chk("def_bits_reached", bits, 1000);
      chk("def_window_79027pm1", (cnt >= 79026 && cnt <= 79028) ? 1 : 0, 1);
      chk("def_os_eq_bit", diff, 0);
      chk("def_upd", int'(def_up), 0);
   endtask

   initial begin
      fork
         main_seq();
         def_seq();
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
